// File: rtl/axi_tdd_ng_pkg.sv
// rtl/axi_tdd_ng_pkg.sv - shared TDD engine types
package axi_tdd_ng_pkg;

  // Frame counter state as seen by every consumer of the counter stage.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

endpackage

// File: rtl/axi_tdd_ng_channel.sv
// rtl/axi_tdd_ng_channel.sv - one gated TDD channel: window flop followed by output flop
module axi_tdd_ng_channel
  import axi_tdd_ng_pkg::*;
#(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      tdd_enable,
  input  state_t                    tdd_cstate,
  input  logic [REGISTER_WIDTH-1:0] tdd_counter,
  input  logic                      ch_en,
  input  logic                      ch_pol,
  input  logic [REGISTER_WIDTH-1:0] ch_on,
  input  logic [REGISTER_WIDTH-1:0] ch_off,
  output logic                      ch_out
);

  logic running;
  logic set_match;
  logic rst_match;
  logic ch_raw_d;
  logic ch_raw_q;
  logic ch_out_d;
  logic ch_out_q;

  assign running   = (tdd_cstate == RUNNING);
  assign set_match = running && (tdd_counter == ch_on);
  assign rst_match = running && (tdd_counter == ch_off);

  // Window level: cleared whenever the counter is not running, off beats on, otherwise hold.
  always_comb begin
    ch_raw_d = ch_raw_q;
    if (!tdd_enable || !running) begin
      ch_raw_d = 1'b0;
    end else if (rst_match) begin
      ch_raw_d = 1'b0;
    end else if (set_match) begin
      ch_raw_d = 1'b1;
    end
  end

  // Output level: disabled channels park at their polarity, enabled ones show the window.
  always_comb begin
    ch_out_d = ch_en ? (ch_raw_q ^ ch_pol) : ch_pol;
  end

  // Both stages share the same synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ch_raw_q <= 1'b0;
      ch_out_q <= 1'b0;
    end else begin
      ch_raw_q <= ch_raw_d;
      ch_out_q <= ch_out_d;
    end
  end

  assign ch_out = ch_out_q;

endmodule

// File: rtl/axi_tdd_ng_channel_gen.sv
// rtl/axi_tdd_ng_channel_gen.sv - bank of CHANNEL_COUNT gated TDD channel outputs
module axi_tdd_ng_channel_gen
  import axi_tdd_ng_pkg::*;
#(
  parameter int CHANNEL_COUNT  = 8,
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     tdd_enable,
  input  state_t                                   tdd_cstate,
  input  logic [REGISTER_WIDTH-1:0]                tdd_counter,
  input  logic                                     tdd_endof_frame,
  input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_en,
  input  logic [CHANNEL_COUNT-1:0]                 tdd_channel_pol,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_on,
  input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0]  tdd_channel_off,
  output logic [CHANNEL_COUNT-1:0]                 tdd_channel
);

  // End-of-frame is reserved for a later per-frame shadow update of the compare values.
  logic unused_endof_frame;
  assign unused_endof_frame = tdd_endof_frame;

  // Every channel is an identical two-flop pipeline, so all outputs share one latency.
  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_channel
    axi_tdd_ng_channel #(
      .REGISTER_WIDTH (REGISTER_WIDTH)
    ) u_channel (
      .clk         (clk),
      .resetn      (resetn),
      .tdd_enable  (tdd_enable),
      .tdd_cstate  (tdd_cstate),
      .tdd_counter (tdd_counter),
      .ch_en       (tdd_channel_en[i]),
      .ch_pol      (tdd_channel_pol[i]),
      .ch_on       (tdd_channel_on[i*REGISTER_WIDTH +: REGISTER_WIDTH]),
      .ch_off      (tdd_channel_off[i*REGISTER_WIDTH +: REGISTER_WIDTH]),
      .ch_out      (tdd_channel[i])
    );
  end

endmodule

// File: tb/tb_axi_tdd_ng_channel_gen.sv
// tb/tb_axi_tdd_ng_channel_gen.sv - scoreboard bench for the TDD channel generator
module tb_axi_tdd_ng_channel_gen;
  import axi_tdd_ng_pkg::*;

  localparam int N = 8;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           tdd_enable = 1'b0;
  state_t         tdd_cstate = IDLE;
  logic [W-1:0]   tdd_counter = '0;
  logic           tdd_endof_frame = 1'b0;
  logic [N-1:0]   ch_en = '0;
  logic [N-1:0]   ch_pol = '0;
  logic [N*W-1:0] ch_on = '0;
  logic [N*W-1:0] ch_off = '0;
  logic [N-1:0]   tdd_channel;

  axi_tdd_ng_channel_gen #(
    .CHANNEL_COUNT  (N),
    .REGISTER_WIDTH (W)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .tdd_enable      (tdd_enable),
    .tdd_cstate      (tdd_cstate),
    .tdd_counter     (tdd_counter),
    .tdd_endof_frame (tdd_endof_frame),
    .tdd_channel_en  (ch_en),
    .tdd_channel_pol (ch_pol),
    .tdd_channel_on  (ch_on),
    .tdd_channel_off (ch_off),
    .tdd_channel     (tdd_channel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  string phase = "reset";

  logic [N-1:0] exp_q[$];
  bit           in_window[N];

  // Hooks applied during frame 0 of the next burst (-1 = unused).
  int drop_at = -1;
  int rst_at  = -1;
  int tog_at  = -1;
  int tog_ch  = 6;

  // Reference: each channel remembers whether its window is open; the output
  // one edge later shows that remembered level through enable/polarity.
  task automatic tick();
    logic [N-1:0] e;
    logic [W-1:0] on_v, off_v;
    @(posedge clk);
    cycle++;
    for (int i = 0; i < N; i++) begin
      if (!resetn) e[i] = 1'b0;
      else if (ch_en[i]) e[i] = in_window[i] ^ ch_pol[i];
      else e[i] = ch_pol[i];
    end
    for (int i = 0; i < N; i++) begin
      on_v  = ch_on[i*W +: W];
      off_v = ch_off[i*W +: W];
      if (!resetn || !tdd_enable || tdd_cstate != RUNNING) in_window[i] = 1'b0;
      else if (tdd_counter == off_v) in_window[i] = 1'b0;
      else if (tdd_counter == on_v) in_window[i] = 1'b1;
    end
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: the output is presented every cycle; compare away from the edge.
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (tdd_channel !== e) begin
        errors++;
        $display("FAIL %s tdd_channel cycle %0d: got %b expected %b", phase, cycle, tdd_channel, e);
      end
    end
  end

  task automatic set_win(int ch, int on_v, int off_v);
    ch_on[ch*W +: W]  = W'(on_v);
    ch_off[ch*W +: W] = W'(off_v);
  endtask

  // One burst: ARMED, WAITING, then `frames` frames of length fl, back to ARMED.
  task automatic run_burst(int fl, int frames);
    bit aborted = 0;
    tdd_cstate = ARMED;
    tick();
    tdd_cstate = WAITING;
    repeat (3) tick();
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < fl; c++) begin
        if (f == 0 && c == drop_at) begin
          tdd_enable = 1'b0;
          aborted = 1;
        end
        if (f == 0 && c == rst_at) resetn = 1'b0;
        if (f == 0 && c == rst_at + 2) resetn = 1'b1;
        if (f == 0 && tog_at >= 0) ch_en[tog_ch] = !(c >= tog_at && c < tog_at + 3);
        tdd_cstate      = aborted ? IDLE : RUNNING;
        tdd_counter     = W'(c);
        tdd_endof_frame = (c == fl - 1);
        tick();
      end
    end
    tdd_endof_frame = 1'b0;
    tdd_counter     = '0;
    tdd_cstate      = ARMED;
    resetn          = 1'b1;
    if (tog_at >= 0) ch_en[tog_ch] = 1'b1;
    repeat (2) tick();
    tdd_cstate = IDLE;
    tdd_enable = 1'b0;
    tick();
    drop_at = -1;
    rst_at  = -1;
    tog_at  = -1;
  endtask

  initial begin
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Directed configuration covering the listed window cases.
    phase = "directed";
    set_win(0, 10, 20);
    set_win(1, 90, 5);
    set_win(2, 30, 30);
    set_win(3, 150, 160);
    set_win(4, 10, 150);
    set_win(5, 10, 20);
    set_win(6, 10, 20);
    set_win(7, 70, 75);
    ch_en  = 8'b1101_1111;
    ch_pol = 8'b0110_0000;
    repeat (2) tick();
    tdd_enable = 1'b1;
    tog_at = 13;
    run_burst(100, 2);
    tdd_enable = 1'b1;
    run_burst(100, 2);

    phase = "drop_enable";
    tdd_enable = 1'b1;
    drop_at = 15;
    run_burst(100, 1);

    phase = "reset_mid_window";
    tdd_enable = 1'b1;
    rst_at = 15;
    run_burst(100, 1);

    phase = "staggered";
    for (int i = 0; i < N; i++) set_win(i, i * 10, i * 10 + 5);
    ch_en  = '1;
    ch_pol = '0;
    tick();
    tdd_enable = 1'b1;
    run_burst(100, 2);

    // Randomized bursts; configuration only changes while tdd_enable is low.
    phase = "random";
    for (int it = 0; it < 30; it++) begin
      int fl;
      fl = int'($urandom_range(10, 40));
      for (int i = 0; i < N; i++) set_win(i, int'($urandom_range(0, fl + 8)), int'($urandom_range(0, fl + 8)));
      ch_en  = N'($urandom);
      ch_pol = N'($urandom);
      if ($urandom_range(0, 3) == 0) drop_at = int'($urandom_range(0, fl - 1));
      if ($urandom_range(0, 4) == 0) rst_at = int'($urandom_range(0, fl - 3));
      if ($urandom_range(0, 2) == 0) begin
        tog_ch = int'($urandom_range(0, N - 1));
        tog_at = int'($urandom_range(0, fl - 1));
      end
      tick();
      tdd_enable = 1'b1;
      run_burst(fl, int'($urandom_range(1, 3)));
    end

    repeat (2) tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
